// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: mode encodings, the 8-entry
// 4-bit-per-channel palette and the default 640x480@60 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_EXT   = 2'd3
    } vga_mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Entry i lives at PALETTE[i]; each entry is {R,G,B} nibbles.
    localparam logic [7:0][11:0] PALETTE = {
        12'hFFF, 12'hFF0, 12'hF80, 12'hF00,
        12'h00F, 12'h060, 12'hF19, 12'h000
    };

    function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap strobe, active-region flag and
// sync level. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             active_o,
    output logic             sync_o
);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // wrap_o fires on the enabled cycle that takes the count back to zero.
    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = ((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and pixel generator with built-in test patterns,
// external pixel input and frame-synchronous mode/select switching.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int CLK_DIV   = 4,
    parameter int COLOR_W   = 4,
    parameter int CHK_SHIFT = 5,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [7:0]           sel,
    input  logic [3*COLOR_W-1:0] pix_in,
    output logic [CNT_W-1:0]     pix_x,
    output logic [CNT_W-1:0]     pix_y,
    output logic                 Hsync,
    output logic                 Vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   vgaRed,
    output logic [COLOR_W-1:0]   vgaGreen,
    output logic [COLOR_W-1:0]   vgaBlue,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int BAR_W = CNT_W + 3;
    localparam int RGB_W = 3 * COLOR_W;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en;
    logic [CNT_W-1:0] h, v;
    logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

    vga_mode_e        mode_q, mode_d;
    logic [7:0]       sel_q, sel_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    assign pix_en    = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .en_i(pix_en),
        .cnt_o(h), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .en_i(h_wrap),
        .cnt_o(v), .wrap_o(v_wrap), .active_o(v_act), .sync_o(v_sync)
    );

    // Solid mode: only an exact one-hot select picks a palette entry.
    logic [7:0] sel_hit;
    // Bars: bar_ge[i] is set when (h*8)/H_ACTIVE >= i, avoiding a divider.
    logic [7:1] bar_ge;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sel_hit
            assign sel_hit[gi] = (sel_q == 8'(1 << gi));
        end
        for (gi = 1; gi < 8; gi++) begin : g_bar_ge
            assign bar_ge[gi] = ({h, 3'b000} >= BAR_W'(gi * H_ACTIVE));
        end
    endgenerate

    logic [2:0]       solid_idx, bar_idx, pal_idx;
    logic             use_ext;
    logic [11:0]      pal_rgb;
    logic [RGB_W-1:0] pat_rgb;

    function automatic logic [COLOR_W-1:0] expand(input logic [3:0] nib);
        return COLOR_W'(nib) << (COLOR_W - 4);
    endfunction

    always_comb begin
        solid_idx = 3'd7;
        bar_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel_hit[i]) solid_idx = 3'(i);
        end
        for (int i = 1; i < 8; i++) begin
            if (bar_ge[i]) bar_idx = 3'(i);
        end
    end

    always_comb begin
        pal_idx = solid_idx;
        use_ext = 1'b0;
        case (mode_q)
            MODE_SOLID: pal_idx = solid_idx;
            MODE_BARS:  pal_idx = bar_idx;
            MODE_CHECK: pal_idx = (h[CHK_SHIFT] ^ v[CHK_SHIFT]) ? 3'd7 : 3'd0;
            default:    use_ext = 1'b1;
        endcase
    end

    assign pal_rgb = palette_rgb(pal_idx);
    assign pat_rgb = use_ext ? pix_in
                             : {expand(pal_rgb[11:8]), expand(pal_rgb[7:4]), expand(pal_rgb[3:0])};

    // Output stage samples the pre-advance position, so it trails pix_x/pix_y by one pixel.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        if (pix_en) begin
            hsync_d = h_sync;
            vsync_d = v_sync;
            de_d    = h_act && v_act;
            rgb_d   = (h_act && v_act) ? pat_rgb : '0;
        end
        frame_start_d = v_wrap;
        frame_cnt_d   = v_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
        mode_d        = v_wrap ? vga_mode_e'(mode) : mode_q;
        sel_d         = v_wrap ? sel : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            mode_q        <= MODE_SOLID;
            sel_q         <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            mode_q        <= mode_d;
            sel_q         <= sel_d;
        end
    end

    assign pix_x       = h;
    assign pix_y       = v;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign de          = de_q;
    assign vgaRed      = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vgaGreen    = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vgaBlue     = rgb_q[COLOR_W-1:0];
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
